// File: rtl/fetch_pc_ctrl_if.sv
// D-stage redirect inputs and F-stage outputs of the fetch PC controller.
// slave: the PC controller itself; master: the pipeline driving it.
interface fetch_pc_ctrl_if;
  logic        stall;
  logic [1:0]  brop_d;
  logic        cmp_result;
  logic [31:0] pc_d;
  logic [15:0] imm16_d;
  logic [25:0] idx26_d;
  logic [31:0] rs_val_d;
  logic        eret_d;
  logic [31:0] epc;
  logic        exc_req;
  logic [31:0] pc_f;
  logic        bd_f;
  logic        flush_fd;
  logic        adel_f;

  modport slave (
    input  stall, brop_d, cmp_result, pc_d, imm16_d, idx26_d, rs_val_d,
           eret_d, epc, exc_req,
    output pc_f, bd_f, flush_fd, adel_f
  );

  modport master (
    output stall, brop_d, cmp_result, pc_d, imm16_d, idx26_d, rs_val_d,
           eret_d, epc, exc_req,
    input  pc_f, bd_f, flush_fd, adel_f
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// F-stage program counter with MIPS delay-slot redirect, exception entry and eret.
// Optional fetch address-error check enabled by defining FETCH_ADEL_CHECK_EN.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic              clk,
  input  logic              reset,
  fetch_pc_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    BROP_NONE = 2'd0,
    BROP_BR   = 2'd1,
    BROP_J    = 2'd2,
    BROP_JR   = 2'd3
  } brop_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_EXC,
    SEL_HOLD,
    SEL_EPC,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_REG
  } sel_e;

  brop_e       brop;
  sel_e        sel;
  logic [31:0] pc_f_q, pc_f_d;
  logic        bd_f_q, bd_f_d;
  logic [31:0] pc_seq;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign brop      = brop_e'(bus.brop_d);
  assign pc_seq    = pc_f_q + 32'd4;
  assign br_target = bus.pc_d + 32'd4 + {{14{bus.imm16_d[15]}}, bus.imm16_d, 2'b00};
  assign j_target  = {bus.pc_d[31:28], bus.idx26_d, 2'b00};

  // Reset is applied in the register; this decode covers priorities below it.
  always_comb begin
    sel = SEL_SEQ;
    if (bus.exc_req) begin
      sel = SEL_EXC;
    end else if (bus.stall) begin
      sel = SEL_HOLD;
    end else if (bus.eret_d) begin
      sel = SEL_EPC;
    end else begin
      unique case (brop)
        BROP_BR:   sel = bus.cmp_result ? SEL_BRANCH : SEL_SEQ;
        BROP_J:    sel = SEL_JUMP;
        BROP_JR:   sel = SEL_REG;
        default:   sel = SEL_SEQ;
      endcase
    end
  end

  always_comb begin
    pc_f_d = pc_seq;
    bd_f_d = (brop != BROP_NONE);
    unique case (sel)
      SEL_EXC: begin
        pc_f_d = EXC_PC;
        bd_f_d = 1'b0;
      end
      SEL_HOLD: begin
        pc_f_d = pc_f_q;
        bd_f_d = bd_f_q;
      end
      SEL_EPC: begin
        pc_f_d = bus.epc;
        bd_f_d = 1'b0;
      end
      SEL_BRANCH: pc_f_d = br_target;
      SEL_JUMP:   pc_f_d = j_target;
      SEL_REG:    pc_f_d = bus.rs_val_d;
      default:    pc_f_d = pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q <= RESET_PC;
      bd_f_q <= 1'b0;
    end else begin
      pc_f_q <= pc_f_d;
      bd_f_q <= bd_f_d;
    end
  end

  assign bus.pc_f     = pc_f_q;
  assign bus.bd_f     = bd_f_q;
  assign bus.flush_fd = ~reset & (bus.exc_req | (bus.eret_d & ~bus.stall));

`ifdef FETCH_ADEL_CHECK_EN
  logic pc_misaligned;
  logic pc_out_of_range;

  assign pc_misaligned   = (pc_f_q[1:0] != 2'b00);
  assign pc_out_of_range = (pc_f_q < IM_BASE) | (pc_f_q > IM_LIMIT);
  assign bus.adel_f      = ~reset & (pc_misaligned | pc_out_of_range);
`else
  // Range bounds only matter when the check is built; fold them into a sink.
  logic unused_im_bounds;
  assign unused_im_bounds = ^{IM_BASE, IM_LIMIT};
  assign bus.adel_f       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: per-cycle model compare plus literal spot checks.
module tb_fetch_pc_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl #(
    .RESET_PC (32'h0000_3000),
    .EXC_PC   (32'h0000_4180),
    .IM_BASE  (32'h0000_3000),
    .IM_LIMIT (32'h0000_6FFC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural PC and delay-slot flag.
  logic [31:0] m_pc;
  logic        m_bd;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [31:0] off;
    off = 32'(signed'(bus.imm16_d)) * 32'd4;
    if (reset) begin
      m_pc = 32'h3000;
      m_bd = 1'b0;
    end else if (bus.exc_req) begin
      m_pc = 32'h4180;
      m_bd = 1'b0;
    end else if (!bus.stall) begin
      if (bus.eret_d) begin
        m_pc = bus.epc;
        m_bd = 1'b0;
      end else begin
        m_bd = (bus.brop_d != 2'd0);
        if (bus.brop_d == 2'd1 && bus.cmp_result) m_pc = bus.pc_d + 32'd4 + off;
        else if (bus.brop_d == 2'd2) m_pc = {bus.pc_d[31:28], 28'(bus.idx26_d) * 28'd4};
        else if (bus.brop_d == 2'd3) m_pc = bus.rs_val_d;
        else m_pc = m_pc + 32'd4;
      end
    end
    m_valid = 1'b1;
  end

  function automatic logic exp_adel(logic [31:0] pc, logic rst);
`ifdef FETCH_ADEL_CHECK_EN
    return !rst && ((pc % 4) != 0 || pc < 32'h3000 || pc > 32'h6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model pc_f", bus.pc_f, m_pc);
      chk("model bd_f", 32'(bus.bd_f), 32'(m_bd));
      chk("model flush_fd", 32'(bus.flush_fd),
          32'(!reset && (bus.exc_req || (bus.eret_d && !bus.stall))));
      chk("model adel_f", 32'(bus.adel_f), 32'(exp_adel(bus.pc_f, reset)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.brop_d = 2'd0; bus.cmp_result = 0; bus.eret_d = 0; bus.exc_req = 0;
  endtask

  task automatic do_jr(input logic [31:0] tgt, input logic adel_exp, input string name);
    bus.brop_d = 2'd3; bus.rs_val_d = tgt;
    step();
    chk({name, " pc"}, bus.pc_f, tgt);
`ifdef FETCH_ADEL_CHECK_EN
    chk({name, " adel"}, 32'(bus.adel_f), 32'(adel_exp));
`else
    chk({name, " adel off"}, 32'(bus.adel_f), 32'(adel_exp & 1'b0));
`endif
  endtask

  initial begin
    logic [31:0] seq [4];
    seq[0] = 32'h3004; seq[1] = 32'h3008; seq[2] = 32'h300C; seq[3] = 32'h3010;
    tests = 0; fails = 0;
    idle();
    bus.pc_d = '0; bus.imm16_d = '0; bus.idx26_d = '0; bus.rs_val_d = '0; bus.epc = '0;

    // Reset with exc/eret pending: reset must win and mask flush.
    reset = 1; bus.exc_req = 1; bus.eret_d = 1;
    step();
    chk("reset pc", bus.pc_f, 32'h3000);
    chk("reset bd", 32'(bus.bd_f), 32'd0);
    chk("reset flush", 32'(bus.flush_fd), 32'd0);
    chk("reset adel", 32'(bus.adel_f), 32'd0);
    reset = 0; idle();

    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq pc", bus.pc_f, seq[i]);
      chk("seq bd", 32'(bus.bd_f), 32'd0);
    end

    // Taken backward branch at 3008.
    bus.pc_d = 32'h3008; bus.brop_d = 2'd1; bus.imm16_d = 16'hFFFE; bus.cmp_result = 1;
    step();
    chk("br taken pc", bus.pc_f, 32'h3004);
    chk("br taken bd", 32'(bus.bd_f), 32'd1);
    idle(); step();
    chk("after br pc", bus.pc_f, 32'h3008);
    chk("after br bd", 32'(bus.bd_f), 32'd0);

    bus.brop_d = 2'd1; bus.cmp_result = 0;
    step();
    chk("br not taken pc", bus.pc_f, 32'h300C);
    chk("br not taken bd", 32'(bus.bd_f), 32'd1);

    // cmp_result ignored for NONE.
    idle(); bus.cmp_result = 1; step();
    chk("none cmp1 pc", bus.pc_f, 32'h3010);

    idle(); bus.pc_d = 32'h3010; bus.brop_d = 2'd2; bus.idx26_d = 26'h0000C40;
    step();
    chk("j pc", bus.pc_f, 32'h3100);
    chk("j bd", 32'(bus.bd_f), 32'd1);

    bus.brop_d = 2'd3; bus.rs_val_d = 32'h3FF0;
    step();
    chk("jr pc", bus.pc_f, 32'h3FF0);

    // Stalled branch; operands change while stalled, only the release edge counts.
    bus.brop_d = 2'd1; bus.pc_d = 32'h3FF0; bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.imm16_d = 16'(i + 1); bus.cmp_result = i[0];
      step();
      chk("stall hold pc", bus.pc_f, 32'h3FF0);
      chk("stall hold bd", 32'(bus.bd_f), 32'd1);
    end
    bus.stall = 0; bus.imm16_d = 16'h0010; bus.cmp_result = 1;
    step();
    chk("stall release pc", bus.pc_f, 32'h4034);
    idle(); step();
    chk("post release pc", bus.pc_f, 32'h4038);
    chk("post release bd", 32'(bus.bd_f), 32'd0);

    // Exception beats stall and eret.
    bus.exc_req = 1; bus.stall = 1; bus.eret_d = 1; bus.epc = 32'h3024; bus.brop_d = 2'd2;
    #1 chk("exc flush", 32'(bus.flush_fd), 32'd1);
    step();
    chk("exc pc", bus.pc_f, 32'h4180);
    chk("exc bd", 32'(bus.bd_f), 32'd0);

    idle(); bus.eret_d = 1; bus.stall = 1;
    #1 chk("eret stalled flush", 32'(bus.flush_fd), 32'd0);
    step();
    chk("eret stalled pc", bus.pc_f, 32'h4180);
    bus.stall = 0;
    #1 chk("eret flush", 32'(bus.flush_fd), 32'd1);
    step();
    chk("eret pc", bus.pc_f, 32'h3024);
    chk("eret bd", 32'(bus.bd_f), 32'd0);
    idle();

    do_jr(32'h3002, 1'b1, "jr 3002");
    do_jr(32'h7000, 1'b1, "jr 7000");
    do_jr(32'h6FFC, 1'b0, "jr 6ffc");
    do_jr(32'h2FFC, 1'b1, "jr 2ffc");

    // Branch target wraps past zero.
    idle(); bus.pc_d = 32'h0; bus.brop_d = 2'd1; bus.cmp_result = 1; bus.imm16_d = 16'h8000;
    step();
    chk("br wrap pc", bus.pc_f, 32'hFFFE_0004);

    // Reset in the middle of a stalled jump.
    bus.brop_d = 2'd2; bus.stall = 1; reset = 1;
    step();
    chk("reset mid-stall pc", bus.pc_f, 32'h3000);
    chk("reset mid-stall bd", 32'(bus.bd_f), 32'd0);
    reset = 0; idle();
    step();
    chk("after reset pc", bus.pc_f, 32'h3004);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
